pipe_ctl: RTL and testbench
===========================

Name: pipe_ctl

Overview:
- Central pipeline sequencer for the five-stage core. Drives the per-stage stall and clr inputs of the IF, ID, EX and MEM stage registers.
- Resolves four hazard sources:
  - data-memory wait
  - taken-branch flush
  - fixed-latency multi-cycle ALU operations occupying EX
  - load-use dependencies between ID and EX
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- FLUSH_CYCLES, 1: number of cycles the ID and EX clr outputs are held after a taken branch; the detection cycle counts as cycle 1; legal range 1..7.
- MULTI_CYCLES, 4: total cycles a multi-cycle ALU op occupies EX; legal range 2..15.
- PERF_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- i_id_rs1  in  `REG_IDX_W  rs1 index of the instruction in ID.
- i_id_rs2  in  `REG_IDX_W  rs2 index of the instruction in ID.
- i_id_rs1_used  in  1  ID instruction reads rs1.
- i_id_rs2_used  in  1  ID instruction reads rs2.
- i_ex_dest_src  in  `DEST_SRC_W  dest source of the instruction in EX.
- i_ex_dest_reg  in  `REG_IDX_W  dest register of the instruction in EX.
- i_ex_multi  in  1  instruction in EX is a multi-cycle ALU op; level signal, sampled only in RUN.
- i_branch_taken  in  1  EX resolved a taken branch this cycle.
- i_mem_busy  in  1  data memory not ready; MEM cannot advance.
- o_if_stall, o_id_stall, o_ex_stall, o_mem_stall  out  1 each  stage stall.
- o_id_clr, o_ex_clr, o_mem_clr  out  1 each  stage clear (the stage register loads a bubble at the next edge).
- o_busy  out  1  state != RUN or branch pending.
- o_perf_stalls  out  PERF_W  count of cycles with o_if_stall=1, saturating.

Behaviour:
- State machine: RUN, FLUSH, MULTI.
- Internal registers:
  - cnt, width 4
  - br_pend, 1 bit
  - perf, PERF_W bits
- All stall/clr outputs are combinational from state and the current inputs (same-cycle effect). o_perf_stalls is registered.
- Reset (clr=1, asynchronous):
  - state=RUN, cnt=0, br_pend=0, perf=0.
  - While clr is high: all stalls=0, o_id_clr=o_ex_clr=o_mem_clr=1, o_busy=0.
- Priority per cycle: mem wait > branch (or br_pend) > multi > load-use.
- Mem wait (any state, i_mem_busy=1):
  - All four stalls=1, all clr=0.
  - state and cnt frozen.
  - If i_branch_taken=1 in this cycle, set br_pend=1.
- Branch (i_mem_busy=0 and (i_branch_taken or br_pend)):
  - o_id_clr=o_ex_clr=1, no stalls. br_pend cleared.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-2; else stay RUN.
  - Branch overrides MULTI entry and load-use in the same cycle.
- FLUSH:
  - Asserts o_id_clr=o_ex_clr=1 each cycle.
  - If cnt=0, go to RUN; else cnt-1.
  - A new branch in FLUSH reloads cnt=FLUSH_CYCLES-2.
- MULTI entry (RUN, i_ex_multi=1, no branch, no mem wait):
  - Go to MULTI with cnt=MULTI_CYCLES-2.
  - This cycle: o_if_stall=o_id_stall=o_ex_stall=1, o_mem_clr=1.
- MULTI:
  - Same outputs as MULTI entry.
  - If cnt=0, go to RUN; else cnt-1.
  - In the cycle after leaving MULTI, i_ex_multi is ignored for one cycle so the completing op is not re-entered.
  - i_branch_taken is ignored while in MULTI.
- Load-use (RUN only, no higher-priority event):
  - Detected when i_ex_dest_src==`DEST_SRC_MEM, i_ex_dest_reg!=0, and (i_id_rs1_used and rs1==dest) or (i_id_rs2_used and rs2==dest).
  - Outputs: o_if_stall=o_id_stall=1, o_ex_clr=1. One cycle only; state stays RUN.
- Register 0 never causes a load-use hazard.
- perf:
  - Increments by 1 on each edge where o_if_stall=1.
  - Holds at 2^PERF_W-1.
  - Not incremented while clr is high.
- Reset mid-MULTI or mid-FLUSH returns immediately to RUN with all registers cleared.

Test Plan:
- Load-use: EX dest_src=`DEST_SRC_MEM, dest=5; ID rs1=5, used=1 -> for 1 cycle o_if_stall=o_id_stall=o_ex_clr=1; next cycle with EX dest_src=NONE -> all 0. With dest=0 -> no stall.
- Branch, FLUSH_CYCLES=2: pulse i_branch_taken -> o_id_clr=o_ex_clr=1 for exactly 2 cycles, o_busy=1 in cycle 2, then RUN.
- Multi op, MULTI_CYCLES=4: hold i_ex_multi=1 -> IF/ID/EX stall and o_mem_clr=1 for exactly 4 cycles; 5th cycle all 0; perf=4.
- Mem wait during MULTI: i_mem_busy=1 for 3 cycles at MULTI cycle 2 -> all stalls for 3 cycles, cnt frozen; MULTI completes after 7 cycles total.
- Branch during mem wait: i_branch_taken=1 with i_mem_busy=1, then busy drops -> clr pulses occur on the first non-busy cycle; br_pend=0 afterwards.
- Async reset: assert clr mid-MULTI between edges -> stalls drop and clr outputs go to 1 immediately; perf=0; after release, state=RUN. Also check saturation: PERF_W=4 with 20 stall cycles -> o_perf_stalls=15.

Source files
------------

// File: rtl/pipe_ctl.sv
// Pipeline sequencer for the five-stage core: stall/clear control for IF, ID, EX and MEM.
// Ports: clk/clr (async active-high reset), ID source operands, EX dest info, multi/branch/mem-busy
//        hazard sources in; per-stage stall and clr, busy flag and saturating stall counter out.
// Stall/clr outputs are combinational (same-cycle effect); o_perf_stalls is registered.

`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif
`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 2'd0
`endif
`ifndef DEST_SRC_ALU
`define DEST_SRC_ALU 2'd1
`endif
`ifndef DEST_SRC_MEM
`define DEST_SRC_MEM 2'd2
`endif

module pipe_ctl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MULTI_CYCLES = 4,
    parameter int PERF_W       = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [`REG_IDX_W-1:0]  i_id_rs1,
    input  logic [`REG_IDX_W-1:0]  i_id_rs2,
    input  logic                   i_id_rs1_used,
    input  logic                   i_id_rs2_used,
    input  logic [`DEST_SRC_W-1:0] i_ex_dest_src,
    input  logic [`REG_IDX_W-1:0]  i_ex_dest_reg,
    input  logic                   i_ex_multi,
    input  logic                   i_branch_taken,
    input  logic                   i_mem_busy,
    output logic                   o_if_stall,
    output logic                   o_id_stall,
    output logic                   o_ex_stall,
    output logic                   o_mem_stall,
    output logic                   o_id_clr,
    output logic                   o_ex_clr,
    output logic                   o_mem_clr,
    output logic                   o_busy,
    output logic [PERF_W-1:0]      o_perf_stalls
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        MULTI = 2'd2
    } state_t;

    // Counter reload values. The cycle in which the event is detected is
    // already the first cycle of the sequence, and the cycle with cnt==0 is
    // the last one, hence the "-2".
    localparam int FLUSH_LOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
    localparam int MULTI_LOAD_I = (MULTI_CYCLES > 1) ? MULTI_CYCLES - 2 : 0;
    localparam logic [3:0] FLUSH_LOAD = FLUSH_LOAD_I[3:0];
    localparam logic [3:0] MULTI_LOAD = MULTI_LOAD_I[3:0];
    localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              br_pend;
    logic              multi_skip;   // blocks re-entry on the cycle after MULTI completes
    logic [PERF_W-1:0] perf;

    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic multi_go;
    logic branch_go;

    // Load-use: EX is a load whose result the ID instruction needs next cycle.
    // x0 is hardwired to zero so it never carries a dependency.
    assign rs1_hit  = i_id_rs1_used && (i_id_rs1 == i_ex_dest_reg);
    assign rs2_hit  = i_id_rs2_used && (i_id_rs2 == i_ex_dest_reg);
    assign load_use = (i_ex_dest_src == `DEST_SRC_MEM) &&
                      (i_ex_dest_reg != '0) &&
                      (rs1_hit || rs2_hit);

    assign multi_go = i_ex_multi && !multi_skip;

    // A branch (live or parked during a memory wait) is acted on in any state
    // except MULTI, where the branch input is ignored.
    assign branch_go = (state != MULTI) && (i_branch_taken || br_pend);

    // ------------------------------------------------------------------
    // Combinational stall / clear decode, in priority order:
    // reset > mem wait > branch > multi > load-use.
    // ------------------------------------------------------------------
    always_comb begin
        o_if_stall  = 1'b0;
        o_id_stall  = 1'b0;
        o_ex_stall  = 1'b0;
        o_mem_stall = 1'b0;
        o_id_clr    = 1'b0;
        o_ex_clr    = 1'b0;
        o_mem_clr   = 1'b0;

        if (clr) begin
            // Bubbles are loaded into ID/EX/MEM while reset is held.
            o_id_clr  = 1'b1;
            o_ex_clr  = 1'b1;
            o_mem_clr = 1'b1;
        end else if (i_mem_busy) begin
            o_if_stall  = 1'b1;
            o_id_stall  = 1'b1;
            o_ex_stall  = 1'b1;
            o_mem_stall = 1'b1;
        end else if (branch_go) begin
            o_id_clr = 1'b1;
            o_ex_clr = 1'b1;
        end else begin
            case (state)
                FLUSH: begin
                    o_id_clr = 1'b1;
                    o_ex_clr = 1'b1;
                end
                MULTI: begin
                    // EX holds the op; MEM gets bubbles meanwhile.
                    o_if_stall = 1'b1;
                    o_id_stall = 1'b1;
                    o_ex_stall = 1'b1;
                    o_mem_clr  = 1'b1;
                end
                default: begin
                    if (multi_go) begin
                        o_if_stall = 1'b1;
                        o_id_stall = 1'b1;
                        o_ex_stall = 1'b1;
                        o_mem_clr  = 1'b1;
                    end else if (load_use) begin
                        // Hold IF/ID one cycle and let a bubble into EX while
                        // the load moves on to MEM.
                        o_if_stall = 1'b1;
                        o_id_stall = 1'b1;
                        o_ex_clr   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_busy        = !clr && ((state != RUN) || br_pend);
    assign o_perf_stalls = perf;

    // ------------------------------------------------------------------
    // State machine, pending-branch flag and stall counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= RUN;
            cnt        <= '0;
            br_pend    <= 1'b0;
            multi_skip <= 1'b0;
            perf       <= '0;
        end else begin
            if (o_if_stall && (perf != {PERF_W{1'b1}})) begin
                perf <= perf + 1'b1;
            end

            if (i_mem_busy) begin
                // Everything freezes; a branch resolved now is remembered and
                // its flush issued on the first cycle memory is ready.
                if (i_branch_taken && (state != MULTI)) begin
                    br_pend <= 1'b1;
                end
            end else if (branch_go) begin
                br_pend    <= 1'b0;
                multi_skip <= 1'b0;
                if (FLUSH_MULTI) begin
                    state <= FLUSH;
                    cnt   <= FLUSH_LOAD;
                end else begin
                    state <= RUN;
                    cnt   <= '0;
                end
            end else begin
                case (state)
                    FLUSH: begin
                        if (cnt == '0) begin
                            state <= RUN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    MULTI: begin
                        if (cnt == '0) begin
                            state      <= RUN;
                            multi_skip <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        multi_skip <= 1'b0;
                        if (multi_go) begin
                            state <= MULTI;
                            cnt   <= MULTI_LOAD;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl (FLUSH_CYCLES=2, MULTI_CYCLES=4, PERF_W=4).
// Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Expected output vector: {if_st, id_st, ex_st, mem_st, id_clr, ex_clr, mem_clr, busy}.

`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif
`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 2'd0
`endif
`ifndef DEST_SRC_MEM
`define DEST_SRC_MEM 2'd2
`endif

module tb_pipe_ctl;

    logic                   clk;
    logic                   clr;
    logic [`REG_IDX_W-1:0]  i_id_rs1;
    logic [`REG_IDX_W-1:0]  i_id_rs2;
    logic                   i_id_rs1_used;
    logic                   i_id_rs2_used;
    logic [`DEST_SRC_W-1:0] i_ex_dest_src;
    logic [`REG_IDX_W-1:0]  i_ex_dest_reg;
    logic                   i_ex_multi;
    logic                   i_branch_taken;
    logic                   i_mem_busy;
    logic                   o_if_stall, o_id_stall, o_ex_stall, o_mem_stall;
    logic                   o_id_clr, o_ex_clr, o_mem_clr, o_busy;
    logic [3:0]             o_perf_stalls;

    int vectors;
    int miscompares;

    pipe_ctl #(
        .FLUSH_CYCLES (2),
        .MULTI_CYCLES (4),
        .PERF_W       (4)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_rs1_used  (i_id_rs1_used),
        .i_id_rs2_used  (i_id_rs2_used),
        .i_ex_dest_src  (i_ex_dest_src),
        .i_ex_dest_reg  (i_ex_dest_reg),
        .i_ex_multi     (i_ex_multi),
        .i_branch_taken (i_branch_taken),
        .i_mem_busy     (i_mem_busy),
        .o_if_stall     (o_if_stall),
        .o_id_stall     (o_id_stall),
        .o_ex_stall     (o_ex_stall),
        .o_mem_stall    (o_mem_stall),
        .o_id_clr       (o_id_clr),
        .o_ex_clr       (o_ex_clr),
        .o_mem_clr      (o_mem_clr),
        .o_busy         (o_busy),
        .o_perf_stalls  (o_perf_stalls)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] outs;
    assign outs = {o_if_stall, o_id_stall, o_ex_stall, o_mem_stall,
                   o_id_clr, o_ex_clr, o_mem_clr, o_busy};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Let combinational outputs settle, then compare the output vector.
    task automatic chk_out(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, {8'h00, outs}, {8'h00, exp});
    endtask

    task automatic chk_perf(input string tag, input logic [3:0] exp);
        chk(tag, {12'h000, o_perf_stalls}, {12'h000, exp});
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronously-timed reset pulse between edges.
    task automatic pulse_reset();
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        clr            = 1'b1;
        i_id_rs1       = '0;
        i_id_rs2       = '0;
        i_id_rs1_used  = 1'b0;
        i_id_rs2_used  = 1'b0;
        i_ex_dest_src  = `DEST_SRC_NONE;
        i_ex_dest_reg  = '0;
        i_ex_multi     = 1'b0;
        i_branch_taken = 1'b0;
        i_mem_busy     = 1'b0;

        // ---- reset state ----
        #2;
        chk_out("reset_outs", 8'b0000_1110);
        chk_perf("reset_perf", 4'd0);
        tick();
        clr = 1'b0;
        chk_out("idle", 8'b0000_0000);
        tick();

        // ---- load-use ----
        i_ex_dest_src = `DEST_SRC_MEM;
        i_ex_dest_reg = 5'd5;
        i_id_rs1      = 5'd5;
        i_id_rs1_used = 1'b1;
        chk_out("lu_rs1", 8'b1100_0100);
        tick();
        i_ex_dest_src = `DEST_SRC_NONE;
        chk_out("lu_release", 8'b0000_0000);
        tick();
        i_ex_dest_src = `DEST_SRC_MEM;
        i_ex_dest_reg = 5'd7;
        i_id_rs1      = 5'd3;
        i_id_rs2      = 5'd7;
        i_id_rs2_used = 1'b1;
        chk_out("lu_rs2", 8'b1100_0100);
        tick();
        i_id_rs2_used = 1'b0;
        chk_out("lu_rs2_unused", 8'b0000_0000);
        tick();
        i_ex_dest_reg = 5'd0;
        i_id_rs1      = 5'd0;
        i_id_rs1_used = 1'b1;
        chk_out("lu_x0", 8'b0000_0000);
        chk_perf("lu_perf", 4'd2);
        tick();
        i_ex_dest_src = `DEST_SRC_NONE;
        i_id_rs1_used = 1'b0;
        tick();

        // ---- branch, two-cycle flush ----
        i_branch_taken = 1'b1;
        chk_out("br_c1", 8'b0000_1100);
        tick();
        i_branch_taken = 1'b0;
        chk_out("br_c2", 8'b0000_1101);
        tick();
        chk_out("br_done", 8'b0000_0000);
        tick();

        // ---- branch overrides multi entry ----
        i_branch_taken = 1'b1;
        i_ex_multi     = 1'b1;
        chk_out("br_vs_multi", 8'b0000_1100);
        tick();
        i_branch_taken = 1'b0;
        chk_out("br_vs_multi_flush", 8'b0000_1101);
        i_ex_multi = 1'b0;
        tick();
        chk_out("br_vs_multi_done", 8'b0000_0000);

        // ---- multi-cycle op, held level ----
        pulse_reset();
        chk_perf("multi_perf0", 4'd0);
        tick();
        i_ex_multi = 1'b1;
        chk_out("multi_c1", 8'b1110_0010);
        tick();
        chk_out("multi_c2", 8'b1110_0011);
        tick();
        chk_out("multi_c3", 8'b1110_0011);
        tick();
        chk_out("multi_c4", 8'b1110_0011);
        tick();
        chk_out("multi_c5", 8'b0000_0000);
        chk_perf("multi_perf", 4'd4);
        i_ex_multi = 1'b0;
        tick();

        // ---- mem wait inside multi ----
        i_ex_multi = 1'b1;
        chk_out("mw_c1", 8'b1110_0010);
        tick();
        i_mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk_out("mw_busy", 8'b1111_0001);
            tick();
        end
        i_mem_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_out("mw_resume", 8'b1110_0011);
            tick();
        end
        chk_out("mw_done", 8'b0000_0000);
        i_ex_multi = 1'b0;
        tick();

        // ---- branch during mem wait ----
        i_mem_busy     = 1'b1;
        i_branch_taken = 1'b1;
        chk_out("bmw_c1", 8'b1111_0000);
        tick();
        i_branch_taken = 1'b0;
        chk_out("bmw_c2", 8'b1111_0001);
        tick();
        i_mem_busy = 1'b0;
        chk_out("bmw_flush1", 8'b0000_1101);
        tick();
        chk_out("bmw_flush2", 8'b0000_1101);
        tick();
        chk_out("bmw_done", 8'b0000_0000);
        tick();

        // ---- async reset mid-multi ----
        i_ex_multi = 1'b1;
        tick();
        chk_out("ar_multi", 8'b1110_0011);
        #1;
        clr = 1'b1;
        chk_out("ar_held", 8'b0000_1110);
        chk_perf("ar_perf", 4'd0);
        i_ex_multi = 1'b0;
        #1;
        clr = 1'b0;
        chk_out("ar_release", 8'b0000_0000);
        tick();
        chk_out("ar_run", 8'b0000_0000);

        // ---- perf saturation ----
        pulse_reset();
        tick();
        i_mem_busy = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        chk_perf("sat_14", 4'd14);
        for (int k = 0; k < 6; k++) tick();
        chk_perf("sat_20", 4'd15);
        i_mem_busy = 1'b0;
        tick();
        chk_perf("sat_hold", 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
